// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter for a shared tristate bus: one registered grant at a time,
// a counted idle turnaround between owners, and optional hold-time preemption.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no grant; arbitrate on any request
// ST_OWN  | exactly one GNT bit high; hold counter running
// ST_TURN | no grant; bus idle for TURN cycles before the next arbitration
module tri_bus_arbiter #(
  parameter int N       = 4,
  parameter int TURN    = 1,
  parameter int MAXHOLD = 8,
  localparam int OW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic [N-1:0]  REQ,
  output logic [N-1:0]  GNT,
  output logic [OW-1:0] OWNER,
  output logic          BUSY,
  output logic          PREEMPT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_t;

  // With preemption disabled the hold counter simply saturates at its full range.
  localparam logic [7:0] HC_MAX  = (MAXHOLD == 0) ? 8'd255 : 8'(MAXHOLD);
  localparam logic [3:0] TC_LOAD = 4'(TURN - 1);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("tri_bus_arbiter: N out of range");
  end
  if (TURN < 1 || TURN > 15) begin : g_bad_turn
    $error("tri_bus_arbiter: TURN out of range");
  end
  if (MAXHOLD < 0 || MAXHOLD > 255) begin : g_bad_maxhold
    $error("tri_bus_arbiter: MAXHOLD out of range");
  end

  state_t        state, state_nxt;
  logic [OW-1:0] ptr, ptr_nxt;
  logic [7:0]    hc, hc_nxt;
  logic [3:0]    tc, tc_nxt;

  logic [N-1:0]  gnt_nxt;
  logic [OW-1:0] owner_nxt;
  logic          busy_nxt;
  logic          preempt_nxt;

  logic          win_valid;
  logic [OW-1:0] win_idx;
  logic [OW-1:0] ptr_adv;
  logic          arb;
  logic          force_rel;
  logic          owner_req;
  logic          competitor;
  logic          hc_sat;

  // Round-robin search upward from ptr, wrapping at N-1.
  always_comb begin
    int idx;
    idx       = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!win_valid && REQ[idx]) begin
        win_valid = 1'b1;
        win_idx   = OW'(idx);
      end
    end
  end

  assign ptr_adv    = (win_idx == OW'(N - 1)) ? '0 : win_idx + OW'(1);
  assign owner_req  = REQ[OWNER];
  assign competitor = |(REQ & ~GNT);
  assign hc_sat     = (hc >= HC_MAX);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      hc      <= '0;
      tc      <= '0;
      GNT     <= '0;
      OWNER   <= '0;
      BUSY    <= 1'b0;
      PREEMPT <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      hc      <= hc_nxt;
      tc      <= tc_nxt;
      GNT     <= gnt_nxt;
      OWNER   <= owner_nxt;
      BUSY    <= busy_nxt;
      PREEMPT <= preempt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    arb       = 1'b0;
    force_rel = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          state_nxt = ST_OWN;
          arb       = 1'b1;
        end
      end
      ST_OWN: begin
        // An owner dropping its request always wins over a preemption.
        if (!owner_req) begin
          state_nxt = ST_TURN;
        end else if ((MAXHOLD != 0) && hc_sat && competitor) begin
          state_nxt = ST_TURN;
          force_rel = 1'b1;
        end
      end
      ST_TURN: begin
        if (tc == 4'd0) begin
          arb       = win_valid;
          state_nxt = win_valid ? ST_OWN : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_nxt     = '0;
    owner_nxt   = '0;
    busy_nxt    = 1'b0;
    preempt_nxt = 1'b0;
    ptr_nxt     = ptr;
    hc_nxt      = hc;
    tc_nxt      = tc;
    case (state_nxt)
      ST_OWN: begin
        busy_nxt = 1'b1;
        if (arb) begin
          gnt_nxt[win_idx] = 1'b1;
          owner_nxt        = win_idx;
          ptr_nxt          = ptr_adv;
          hc_nxt           = 8'd1;
        end else begin
          gnt_nxt   = GNT;
          owner_nxt = OWNER;
          hc_nxt    = hc_sat ? hc : hc + 8'd1;
        end
      end
      ST_TURN: begin
        hc_nxt = '0;
        if (state != ST_TURN) begin
          tc_nxt      = TC_LOAD;
          preempt_nxt = force_rel;
        end else begin
          tc_nxt = tc - 4'd1;
        end
      end
      default: begin
        hc_nxt = '0;
        tc_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench: a cycle table for the default-style instance (TURN=1, MAXHOLD=4)
// plus hand sequences for the lost pulse and a TURN=3, MAXHOLD=0 instance.
module tb_tri_bus_arbiter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_a, rstn_b;
  logic [3:0] req_a, req_b, gnt_a, gnt_b;
  logic [1:0] owner_a, owner_b;
  logic       busy_a, busy_b, pre_a, pre_b;

  int n_checks = 0;
  int n_pass   = 0;
  logic run_mon = 1'b0;
  logic [3:0] prev_a = 4'b0, prev_b = 4'b0;

  tri_bus_arbiter #(.N(4), .TURN(1), .MAXHOLD(4)) dut_a (
    .CLK(clk), .RSTN(rstn_a), .REQ(req_a), .GNT(gnt_a),
    .OWNER(owner_a), .BUSY(busy_a), .PREEMPT(pre_a)
  );

  tri_bus_arbiter #(.N(4), .TURN(3), .MAXHOLD(0)) dut_b (
    .CLK(clk), .RSTN(rstn_b), .REQ(req_b), .GNT(gnt_b),
    .OWNER(owner_b), .BUSY(busy_b), .PREEMPT(pre_b)
  );

  typedef struct {
    logic       rstn;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       pre;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int r, int q, int g, int o, int b, int p);
    vec_t v;
    v.rstn  = 1'(r);
    v.req   = 4'(q);
    v.gnt   = 4'(g);
    v.owner = 2'(o);
    v.busy  = 1'(b);
    v.pre   = 1'(p);
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // Structural bus rules on both instances every cycle.
  always @(negedge clk) begin
    if (run_mon) begin
      chk("onehot_a", 8'($onehot0(gnt_a)), 8'd1);
      chk("onehot_b", 8'($onehot0(gnt_b)), 8'd1);
      chk("switch_a", 8'(prev_a != 4'b0 && gnt_a != 4'b0 && gnt_a != prev_a), 8'd0);
      chk("switch_b", 8'(prev_b != 4'b0 && gnt_b != 4'b0 && gnt_b != prev_b), 8'd0);
    end
    prev_a = gnt_a;
    prev_b = gnt_b;
  end

  initial begin
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    req_a  = 4'b0;
    req_b  = 4'b0;

    // reset state
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);
    // single requester held, then released
    for (int k = 0; k < 5; k++) add(1, 4'b0001, 4'b0001, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    // all requesting: 4-cycle holds with preempt gaps
    add(0, 4'b1111, 0, 0, 0, 0);
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) add(1, 4'b1111, 1 << g, g, 1, 0);
      add(1, 4'b1111, 0, 0, 0, 1);
    end
    for (int k = 0; k < 4; k++) add(1, 4'b1111, 4'b0001, 0, 1, 0);
    // owner drops on the preemption edge: normal release
    add(1, 4'b1110, 0, 0, 0, 0);
    add(1, 4'b1110, 4'b0010, 1, 1, 0);
    // early release, then a new requester after one idle cycle
    add(0, 0, 0, 0, 0, 0);
    add(1, 4'b0001, 4'b0001, 0, 1, 0);
    add(1, 4'b0001, 4'b0001, 0, 1, 0);
    add(1, 4'b0100, 0, 0, 0, 0);
    add(1, 4'b0100, 4'b0100, 2, 1, 0);
    // reset mid-ownership clears the pointer
    add(0, 4'b0100, 0, 0, 0, 0);
    add(1, 4'b1010, 4'b0010, 1, 1, 0);
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);
    // lone owner keeps the bus, preempted when a competitor appears
    add(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) add(1, 4'b0010, 4'b0010, 1, 1, 0);
    add(1, 4'b1010, 0, 0, 0, 1);
    add(1, 4'b1010, 4'b1000, 3, 1, 0);
    add(1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0);

    run_mon = 1'b1;
    foreach (vecs[i]) begin
      rstn_a = vecs[i].rstn;
      req_a  = vecs[i].req;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), {gnt_a, owner_a, busy_a, pre_a},
          {vecs[i].gnt, vecs[i].owner, vecs[i].busy, vecs[i].pre});
    end

    // sub-cycle pulse between edges is not latched
    req_a = 4'b0;
    @(posedge clk);
    #2 req_a = 4'b0001;
    #3 req_a = 4'b0000;
    @(posedge clk);
    #1 chk("lost_pulse", {gnt_a, owner_a, busy_a, pre_a}, 8'h00);
    @(posedge clk);
    #1 chk("lost_pulse2", {gnt_a, owner_a, busy_a, pre_a}, 8'h00);

    // TURN=3, MAXHOLD=0: no preemption, three idle cycles on release
    rstn_b = 1'b1;
    req_b  = 4'b0011;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1 chk($sformatf("b_own%0d", k), {gnt_b, owner_b, busy_b, pre_b}, {4'b0001, 2'd0, 1'b1, 1'b0});
    end
    req_b = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 chk($sformatf("b_turn%0d", k), {gnt_b, owner_b, busy_b, pre_b}, 8'h00);
    end
    @(posedge clk);
    #1 chk("b_next", {gnt_b, owner_b, busy_b, pre_b}, {4'b0010, 2'd1, 1'b1, 1'b0});
    req_b = 4'b0;
    @(posedge clk);
    #1 chk("b_release", {gnt_b, owner_b, busy_b, pre_b}, 8'h00);
    @(posedge clk);
    @(posedge clk);

    run_mon = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
